eth_tx_mmio_responder: RTL and testbench

ETH_TX_MMIO_RESPONDER -- requirements
Module: eth_tx_mmio_responder

---
 rtl/eth_mmio_pkg.sv | 36 +++
 rtl/eth_tx_buf_ram.sv | 33 +++
 rtl/eth_tx_mmio_responder.sv | 214 +++++++++++++++++++++
 tb/tb_eth_tx_mmio_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mmio_pkg.sv
// Shared definitions for the Ethernet TX MMIO responder: register map,
// access-size encoding, TX FSM states and an alignment helper.
package eth_mmio_pkg;

  localparam logic [15:0] BufBase    = 16'h0800;
  localparam logic [15:0] RegSend    = 16'h1018;
  localparam logic [15:0] RegReady   = 16'h101C;
  localparam logic [15:0] RegSize    = 16'h1028;
  localparam logic [15:0] RegPending = 16'h1030;
  localparam logic [15:0] RegIntEn   = 16'h1034;

  typedef enum logic [1:0] {
    OpByte   = 2'b00,
    OpHalf   = 2'b01,
    OpWord   = 2'b10,
    OpDouble = 2'b11
  } op_size_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } tx_state_e;

  // True when the low address bits are naturally aligned for the access size.
  function automatic logic acc_aligned(input logic [2:0] addr_lo, input op_size_e sz);
    logic ok;
    case (sz)
      OpByte:  ok = 1'b1;
      OpHalf:  ok = (addr_lo[0] == 1'b0);
      OpWord:  ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/eth_tx_buf_ram.sv
// TX packet buffer: one byte-enable write port and two asynchronous read
// ports (MAC stream side and CPU side). Contents are not reset.
module eth_tx_buf_ram #(
  parameter int unsigned Words = 512,
  parameter int unsigned Lanes = 4,
  parameter int unsigned Aw    = $clog2(Words)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [Lanes-1:0]     be_i,
  input  logic [Aw-1:0]        waddr_i,
  input  logic [8*Lanes-1:0]   wdata_i,
  input  logic [Aw-1:0]        strm_addr_i,
  output logic [8*Lanes-1:0]   strm_data_o,
  input  logic [Aw-1:0]        cpu_addr_i,
  output logic [8*Lanes-1:0]   cpu_data_o
);

  logic [8*Lanes-1:0] mem_q [Words];

  // Byte-lane write of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign strm_data_o = mem_q[strm_addr_i];
  assign cpu_data_o  = mem_q[cpu_addr_i];

endmodule

// File: rtl/eth_tx_mmio_responder.sv
// Ethernet TX MMIO responder: CPU fills a packet buffer over MMIO, writes a
// length and a send strobe, and the block streams the packet as beats.
// Optional feature: define ETH_TX_BUF_READBACK_EN to make buffer-region
// reads return buffer contents (otherwise they read as 0).
module eth_tx_mmio_responder
  import eth_mmio_pkg::*;
#(
  parameter int unsigned buf_size_p       = 2048,
  parameter int unsigned data_width_p     = 32,
  parameter int unsigned reg_addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [reg_addr_width_p-1:0] addr_i,
  input  logic                        write_en_i,
  input  logic                        read_en_i,
  input  logic [1:0]                  op_size_i,
  input  logic [data_width_p-1:0]     write_data_i,
  output logic [data_width_p-1:0]     read_data_o,
  output logic                        read_data_v_o,
  output logic                        tx_interrupt_pending_o,
  output logic [data_width_p-1:0]     tx_data_o,
  output logic [data_width_p/8-1:0]   tx_keep_o,
  output logic                        tx_valid_o,
  output logic                        tx_last_o,
  input  logic                        tx_ready_i
);

  localparam int unsigned Lanes  = data_width_p / 8;
  localparam int unsigned OffW   = $clog2(Lanes);
  localparam int unsigned Words  = buf_size_p / Lanes;
  localparam int unsigned WordAw = $clog2(Words);
  localparam int unsigned SizeW  = $clog2(buf_size_p) + 1;

`ifdef ETH_TX_BUF_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  tx_state_e               state_q, state_d;
  logic [WordAw-1:0]       beat_q, beat_d;
  logic [SizeW-1:0]        size_q, size_d;
  logic                    en_q, en_d;
  logic                    pend_q, pend_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  // Access decode
  logic [31:0]                 addr32, buf_off;
  logic [reg_addr_width_p-1:0] addr_word;
  logic [OffW-1:0]             lane_off;
  logic [3:0]                  acc_bytes;
  logic                        legal, in_buf, idle, reg_wr;
  logic                        hit_send, hit_ready, hit_size, hit_pend, hit_inten;
  logic [Lanes-1:0]            be;
  logic [data_width_p-1:0]     bmask, rmask, wdata_sh, word_val;
  logic [WordAw-1:0]           buf_word;
  logic [data_width_p-1:0]     strm_data, cpu_data;

  // Stream control
  logic [SizeW-1:0] last_idx;
  logic [OffW-1:0]  size_rem;
  logic             last_beat, fire, size_ok, send_go;

  assign addr32    = 32'(addr_i);
  assign buf_off   = addr32 - 32'(BufBase);
  assign in_buf    = (addr32 >= 32'(BufBase)) && (buf_off < buf_size_p);
  assign buf_word  = WordAw'(buf_off >> OffW);
  assign addr_word = {addr_i[reg_addr_width_p-1:OffW], {OffW{1'b0}}};
  assign lane_off  = addr_i[OffW-1:0];
  assign acc_bytes = 4'(1) << op_size_i;
  assign legal     = acc_aligned(addr_i[2:0], op_size_e'(op_size_i)) &&
                     (32'(acc_bytes) <= Lanes);
  assign idle      = (state_q == StIdle);
  assign reg_wr    = write_en_i && legal;
  assign wdata_sh  = data_width_p'(write_data_i << {lane_off, 3'b000});

  assign hit_send  = !in_buf && (addr_word == reg_addr_width_p'(RegSend));
  assign hit_ready = !in_buf && (addr_word == reg_addr_width_p'(RegReady));
  assign hit_size  = !in_buf && (addr_word == reg_addr_width_p'(RegSize));
  assign hit_pend  = !in_buf && (addr_word == reg_addr_width_p'(RegPending));
  assign hit_inten = !in_buf && (addr_word == reg_addr_width_p'(RegIntEn));

  assign size_ok   = (size_q != '0) && (32'(size_q) <= buf_size_p);
  assign send_go   = reg_wr && hit_send && idle && size_ok;
  assign last_idx  = SizeW'((size_q + SizeW'(Lanes - 1)) >> OffW) - SizeW'(1);
  assign last_beat = (SizeW'(beat_q) == last_idx);
  assign size_rem  = size_q[OffW-1:0];
  assign fire      = tx_valid_o && tx_ready_i;

  // Byte enables for writes and the right-aligned mask for read data.
  always_comb begin
    be    = '0;
    bmask = '0;
    rmask = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (i < 32'(acc_bytes)) rmask[8*i +: 8] = 8'hff;
      if ((i >= 32'(lane_off)) && (i < 32'(lane_off) + 32'(acc_bytes))) be[i] = legal;
      bmask[8*i +: 8] = {8{be[i]}};
    end
  end

  eth_tx_buf_ram #(
    .Words (Words),
    .Lanes (Lanes),
    .Aw    (WordAw)
  ) u_buf (
    .clk_i       (clk_i),
    .we_i        (reg_wr && in_buf && idle),
    .be_i        (be),
    .waddr_i     (buf_word),
    .wdata_i     (wdata_sh),
    .strm_addr_i (beat_q),
    .strm_data_o (strm_data),
    .cpu_addr_i  (buf_word),
    .cpu_data_o  (cpu_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // FSM next state and beat index.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        if (send_go) state_d = StSend;
      end
      StSend: begin
        if (fire) begin
          if (last_beat) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + WordAw'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: beat stream; keep trims the tail of the final beat.
  always_comb begin
    tx_valid_o = (state_q == StSend);
    tx_last_o  = 1'b0;
    tx_keep_o  = '0;
    tx_data_o  = '0;
    if (state_q == StSend) begin
      tx_data_o = strm_data;
      tx_last_o = last_beat;
      tx_keep_o = '1;
      if (last_beat && (size_rem != '0)) begin
        for (int unsigned i = 0; i < Lanes; i++) tx_keep_o[i] = (i < 32'(size_rem));
      end
    end
  end

  // Control registers; pending set takes priority over write-1-clear.
  always_comb begin
    size_d = size_q;
    en_d   = en_q;
    pend_d = pend_q;
    if (reg_wr && hit_size && idle) begin
      size_d = SizeW'((data_width_p'(size_q) & ~bmask) | (wdata_sh & bmask));
    end
    if (reg_wr && hit_inten && be[0]) en_d = wdata_sh[0];
    if (reg_wr && hit_pend && be[0] && wdata_sh[0]) pend_d = 1'b0;
    if (fire && last_beat) pend_d = 1'b1;
  end

  // Read response: word select, then shift down and mask to access size.
  always_comb begin
    word_val = '0;
    if (in_buf)         word_val = ReadbackEn ? cpu_data : '0;
    else if (hit_ready) word_val = data_width_p'(idle);
    else if (hit_size)  word_val = data_width_p'(size_q);
    else if (hit_pend)  word_val = data_width_p'(pend_q);
    else if (hit_inten) word_val = data_width_p'(en_q);
    rvalid_d = read_en_i && !write_en_i;
    rdata_d  = '0;
    if (rvalid_d && legal) rdata_d = (word_val >> {lane_off, 3'b000}) & rmask;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_q   <= '0;
      size_q   <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      size_q   <= size_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign read_data_o            = rdata_q;
  assign read_data_v_o          = rvalid_q;
  assign tx_interrupt_pending_o = pend_q & en_q;

endmodule

// File: tb/tb_eth_tx_mmio_responder.sv
// Randomized self-checking bench for eth_tx_mmio_responder with a
// byte-array reference model of the buffer and register map.
module tb_eth_tx_mmio_responder;

  localparam int unsigned BufSize  = 2048;
  localparam int unsigned SizeMask = (1 << ($clog2(BufSize) + 1)) - 1;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [15:0] addr_i;
  logic        write_en_i, read_en_i;
  logic [1:0]  op_size_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        read_data_v_o;
  logic        tx_interrupt_pending_o;
  logic [31:0] tx_data_o;
  logic [3:0]  tx_keep_o;
  logic        tx_valid_o, tx_last_o, tx_ready_i;

  int tests_run = 0;
  int tests_failed = 0;

  byte unsigned buf_m [BufSize];
  int unsigned  size_m;
  bit           en_m, pend_m, busy_m;

  always #5 clk_i = ~clk_i;

  eth_tx_mmio_responder #(
    .buf_size_p       (BufSize),
    .data_width_p     (32),
    .reg_addr_width_p (16)
  ) dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .addr_i                 (addr_i),
    .write_en_i             (write_en_i),
    .read_en_i              (read_en_i),
    .op_size_i              (op_size_i),
    .write_data_i           (write_data_i),
    .read_data_o            (read_data_o),
    .read_data_v_o          (read_data_v_o),
    .tx_interrupt_pending_o (tx_interrupt_pending_o),
    .tx_data_o              (tx_data_o),
    .tx_keep_o              (tx_keep_o),
    .tx_valid_o             (tx_valid_o),
    .tx_last_o              (tx_last_o),
    .tx_ready_i             (tx_ready_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit legal_acc(input int unsigned addr, input int unsigned sz);
    int unsigned nb;
    nb = 1 << sz;
    return (nb <= 4) && ((addr % nb) == 0);
  endfunction

  function automatic bit in_buf(input int unsigned a);
    return (a >= 'h800) && (a < 'h800 + BufSize);
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned addr, input int unsigned sz);
    int unsigned nb;
    logic [31:0] w;
    if (!legal_acc(addr, sz)) return 32'd0;
    nb = 1 << sz;
    w = 32'd0;
    if (in_buf(addr)) begin
`ifdef ETH_TX_BUF_READBACK_EN
      for (int k = 0; k < nb; k++) w[8*k +: 8] = buf_m[addr - 'h800 + k];
`endif
      return w;
    end
    case (addr & ~32'd3)
      'h101C:  w = busy_m ? 32'd0 : 32'd1;
      'h1028:  w = size_m;
      'h1030:  w = {31'd0, pend_m};
      'h1034:  w = {31'd0, en_m};
      default: w = 32'd0;
    endcase
    w = w >> (8 * (addr % 4));
    if (nb < 4) w = w & ((32'd1 << (8 * nb)) - 1);
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned b);
    return {buf_m[4*b+3], buf_m[4*b+2], buf_m[4*b+1], buf_m[4*b]};
  endfunction

  task automatic model_write(input int unsigned addr, input int unsigned sz,
                             input logic [31:0] data);
    int unsigned nb, wa;
    logic [31:0] v;
    if (!legal_acc(addr, sz)) return;
    nb = 1 << sz;
    wa = addr & ~32'd3;
    if (in_buf(addr)) begin
      if (!busy_m) for (int k = 0; k < nb; k++) buf_m[addr - 'h800 + k] = data[8*k +: 8];
    end else if (wa == 'h1028) begin
      if (!busy_m) begin
        v = size_m;
        for (int k = 0; k < nb; k++) v[8*((addr % 4) + k) +: 8] = data[8*k +: 8];
        size_m = v & SizeMask;
      end
    end else if (wa == 'h1034) begin
      if ((addr % 4) == 0) en_m = data[0];
    end else if (wa == 'h1030) begin
      if (((addr % 4) == 0) && data[0]) pend_m = 1'b0;
    end else if (wa == 'h1018) begin
      if (!busy_m && (size_m > 0) && (size_m <= BufSize)) busy_m = 1'b1;
    end
  endtask

  task automatic mmio_write(input int unsigned addr, input int unsigned sz,
                            input logic [31:0] data);
    addr_i = 16'(addr);
    op_size_i = 2'(sz);
    write_data_i = data;
    write_en_i = 1'b1;
    step();
    write_en_i = 1'b0;
    model_write(addr, sz, data);
    check("rvalid_after_wr", read_data_v_o, 0);
  endtask

  task automatic mmio_read(input int unsigned addr, input int unsigned sz);
    logic [31:0] exp;
    exp = ref_read(addr, sz);
    addr_i = 16'(addr);
    op_size_i = 2'(sz);
    read_en_i = 1'b1;
    step();
    read_en_i = 1'b0;
    check("rd_valid", read_data_v_o, 1);
    check($sformatf("rd_%0h_sz%0d", addr, sz), read_data_o, exp);
  endtask

  // Drive tx_ready_i with random stalls and check every presented beat.
  task automatic stream(input int unsigned stall_pct);
    int unsigned nb, beat, budget;
    logic [3:0] kexp;
    bit rdy;
    nb = (size_m + 3) / 4;
    beat = 0;
    budget = 0;
    while ((beat < nb) && (budget < 400)) begin
      kexp = ((beat == nb - 1) && (size_m % 4 != 0)) ? 4'((1 << (size_m % 4)) - 1) : 4'hF;
      check("tx_valid", tx_valid_o, 1);
      check($sformatf("tx_data_b%0d", beat), tx_data_o, exp_word(beat));
      check("tx_keep", tx_keep_o, kexp);
      check("tx_last", tx_last_o, beat == nb - 1);
      rdy = ($urandom_range(99, 0) >= stall_pct);
      tx_ready_i = rdy;
      step();
      budget++;
      if (rdy) beat++;
    end
    tx_ready_i = 1'b0;
    if (beat < nb) check("stream_timeout", beat, nb);
    busy_m = 1'b0;
    pend_m = 1'b1;
    check("tx_valid_done", tx_valid_o, 0);
    check("irq_after_send", tx_interrupt_pending_o, en_m & pend_m);
  endtask

  int unsigned raddrs [8];
  int unsigned rsz, nw;

  initial begin
    raddrs = '{'h1018, 'h101C, 'h1028, 'h1029, 'h1030, 'h1034, 'h1040, 'h0804};
    reset_n_i = 1'b1;
    addr_i = '0;
    write_en_i = 1'b0;
    read_en_i = 1'b0;
    op_size_i = 2'd2;
    write_data_i = '0;
    tx_ready_i = 1'b0;
    size_m = 0; en_m = 0; pend_m = 0; busy_m = 0;
    #2 reset_n_i = 1'b0;
    step();
    step();
    check("rst_rdata", read_data_o, 0);
    check("rst_rvalid", read_data_v_o, 0);
    check("rst_valid", tx_valid_o, 0);
    check("rst_last", tx_last_o, 0);
    check("rst_keep", tx_keep_o, 0);
    check("rst_irq", tx_interrupt_pending_o, 0);
    reset_n_i = 1'b1;
    step();
    mmio_read('h101C, 2);
    mmio_read('h1028, 2);
    mmio_read('h1030, 2);

    // Single full-word beat.
    mmio_write('h800, 2, 32'h11223344);
    mmio_write('h1028, 2, 4);
    mmio_write('h1018, 2, 0);
    stream(0);
    mmio_read('h1030, 2);
    mmio_write('h1030, 2, 1);

    // Six bytes with a five-cycle stall on beat 0.
    mmio_write('h800, 2, 32'hA5A55A5A);
    mmio_write('h804, 2, 32'hDEADBEEF);
    mmio_write('h1028, 2, 6);
    mmio_write('h1018, 2, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", tx_valid_o, 1);
      check("stall_data", tx_data_o, 32'hA5A55A5A);
      check("stall_keep", tx_keep_o, 4'hF);
      check("stall_last", tx_last_o, 0);
      step();
    end
    stream(0);

    // Register reads and ignored size writes while sending.
    mmio_write('h1028, 2, 8);
    mmio_write('h1018, 2, 0);
    mmio_read('h101C, 2);
    mmio_write('h1028, 2, 3);
    mmio_read('h1028, 2);
    mmio_write('h800, 2, 32'h0BAD0BAD);
    stream(30);

    // Pending set wins over a same-cycle clear.
    mmio_write('h1034, 2, 1);
    mmio_write('h1030, 2, 1);
    mmio_write('h1028, 2, 4);
    mmio_write('h1018, 2, 0);
    tx_ready_i = 1'b1;
    addr_i = 16'h1030;
    op_size_i = 2'd2;
    write_data_i = 32'd1;
    write_en_i = 1'b1;
    step();
    write_en_i = 1'b0;
    tx_ready_i = 1'b0;
    busy_m = 1'b0;
    pend_m = 1'b1;
    check("pend_set_wins", tx_interrupt_pending_o, 1);
    mmio_write('h1030, 2, 1);
    check("irq_cleared", tx_interrupt_pending_o, 0);

    // Rejected sends and an ignored misaligned halfword.
    mmio_write('h1028, 2, 0);
    mmio_write('h1018, 2, 0);
    check("size0_no_send", tx_valid_o, 0);
    mmio_write('h1028, 2, BufSize + 4);
    mmio_write('h1018, 2, 0);
    check("oversize_no_send", tx_valid_o, 0);
    mmio_read('h101C, 2);
    mmio_write('h800, 2, 32'hCAFEF00D);
    mmio_write('h801, 1, 32'h0000BEEF);
    mmio_write('h800, 3, 32'h12345678);
    mmio_read('h802, 2);
    mmio_write('h1028, 2, 4);
    mmio_write('h1018, 2, 0);
    stream(0);

    // Randomized packets, sub-word buffer writes and register reads.
    for (int it = 0; it < 25; it++) begin
      rsz = $urandom_range(64, 1);
      nw = (rsz + 3) / 4;
      for (int w = 0; w < nw; w++) mmio_write('h800 + 4 * w, 2, $urandom);
      for (int j = 0; j < 3; j++) begin
        mmio_write('h800 + $urandom_range(rsz - 1, 0), $urandom_range(3, 0), $urandom);
      end
      if ($urandom_range(3, 0) == 0) mmio_write('h1034, 2, $urandom_range(1, 0));
      mmio_write('h1028, $urandom_range(1, 0) + 1, rsz);
      mmio_read(raddrs[$urandom_range(7, 0)], $urandom_range(2, 0));
      mmio_write('h1018, 2, 0);
      stream($urandom_range(60, 0));
      mmio_read('h1030, 2);
      if ($urandom_range(1, 0) == 1) mmio_write('h1030, 2, 1);
    end

    // Reset in the middle of a send.
    mmio_write('h1034, 2, 1);
    mmio_write('h1028, 2, 16);
    mmio_write('h1018, 2, 0);
    step();
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_mid_valid", tx_valid_o, 0);
    check("rst_mid_irq", tx_interrupt_pending_o, 0);
    step();
    reset_n_i = 1'b1;
    size_m = 0; en_m = 0; pend_m = 0; busy_m = 0;
    step();
    mmio_read('h101C, 2);
    mmio_read('h1030, 2);
    mmio_read('h1028, 2);
    check("rst_mid_valid_after", tx_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
